// File: rtl/if_adder.sv
// PC-relative target adder: combinational target plus carry/overflow/alignment
// flags, and a one-cycle registered copy qualified by in_valid.
module if_adder #(
  parameter int N          = 32,
  parameter int ALIGN_BITS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] address,
  input  logic [N-1:0] imm_out,
  input  logic         in_valid,
  output logic [N-1:0] pc_signed_offset,
  output logic         carry_out,
  output logic         signed_overflow,
  output logic         misaligned,
  output logic [N-1:0] target_q,
  output logic [2:0]   flags_q,
  output logic         valid_q
);

  logic [N:0]   w_sum;
  logic         w_misaligned;
  logic [N-1:0] r_target;
  logic [2:0]   r_flags;
  logic         r_valid;

  // One extra bit on the sum gives the unsigned carry out of the MSB.
  assign w_sum            = {1'b0, address} + {1'b0, imm_out};
  assign pc_signed_offset = w_sum[N-1:0];
  assign carry_out        = w_sum[N];
  assign signed_overflow  = (address[N-1] == imm_out[N-1]) &&
                            (w_sum[N-1] != address[N-1]);

  generate
    if (ALIGN_BITS == 0) begin : g_no_align
      assign w_misaligned = 1'b0;
    end else begin : g_align
      assign w_misaligned = |w_sum[ALIGN_BITS-1:0];
    end
  endgenerate

  assign misaligned = w_misaligned;

  // Hold target/flags when idle so unknown inputs never reach the registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_target <= '0;
      r_flags  <= '0;
      r_valid  <= 1'b0;
    end else if (in_valid) begin
      r_target <= w_sum[N-1:0];
      r_flags  <= {w_misaligned, signed_overflow, w_sum[N]};
      r_valid  <= 1'b1;
    end else begin
      r_valid  <= 1'b0;
    end
  end

  assign target_q = r_target;
  assign flags_q  = r_flags;
  assign valid_q  = r_valid;

endmodule

// File: tb/tb_if_adder.sv
// Bench for if_adder: vector table, registered-path sequences and randomized
// traffic checked against an arithmetic reference model.
module tb_if_adder;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] imm_out;
  logic        in_valid;
  logic [31:0] pc_signed_offset;
  logic        carry_out;
  logic        signed_overflow;
  logic        misaligned;
  logic [31:0] target_q;
  logic [2:0]  flags_q;
  logic        valid_q;

  int n_checks = 0;
  int n_pass   = 0;

  if_adder #(.N(32), .ALIGN_BITS(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .address          (address),
    .imm_out          (imm_out),
    .in_valid         (in_valid),
    .pc_signed_offset (pc_signed_offset),
    .carry_out        (carry_out),
    .signed_overflow  (signed_overflow),
    .misaligned       (misaligned),
    .target_q         (target_q),
    .flags_q          (flags_q),
    .valid_q          (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] t;
    logic        c;
    logic        v;
    logic        m;
  } vec_t;

  // Reference: plain wide arithmetic on unsigned and signed interpretations.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] t, output logic c,
                                output logic v, output logic m);
    longint unsigned ua, ub, us;
    longint sa, sb, ss;
    ua = a; ub = b; us = ua + ub;
    sa = $signed(a); sb = $signed(b); ss = sa + sb;
    t = us[31:0];
    c = (us >= 64'h1_0000_0000);
    v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    m = (t % 4) != 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_comb(input string name, input logic [31:0] t,
                            input logic c, input logic v, input logic m);
    check({name, ".target"}, 64'(pc_signed_offset), 64'(t));
    check({name, ".flags"}, 64'({misaligned, signed_overflow, carry_out}), 64'({m, v, c}));
  endtask

  logic [31:0] exp_tq;
  logic [2:0]  exp_fq;
  logic        exp_vq;

  // Drive at negedge, let one posedge happen, then update and check the model.
  task automatic step(input logic r, input logic iv, input logic [31:0] a,
                      input logic [31:0] b, input logic xin, input string name);
    logic [31:0] t; logic c, v, m;
    @(negedge clk);
    rst = r; in_valid = iv;
    if (xin) begin address = 'x; imm_out = 'x; end
    else begin address = a; imm_out = b; end
    @(posedge clk);
    #1;
    if (r) begin
      exp_tq = '0; exp_fq = '0; exp_vq = 1'b0;
    end else if (iv) begin
      model(a, b, t, c, v, m);
      exp_tq = t; exp_fq = {m, v, c}; exp_vq = 1'b1;
    end else begin
      exp_vq = 1'b0;
    end
    check({name, ".target_q"}, 64'(target_q), 64'(exp_tq));
    check({name, ".flags_q"}, 64'(flags_q), 64'(exp_fq));
    check({name, ".valid_q"}, 64'(valid_q), 64'(exp_vq));
    if (!xin) begin
      model(a, b, t, c, v, m);
      check_comb({name, ".comb"}, t, c, v, m);
    end
  endtask

  vec_t vecs[8];

  initial begin
    logic [31:0] t, ra, rb;
    logic c, v, m;
    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'd123,       32'h0000_007B, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{32'd100,       32'hFFFF_FFD8, 32'h0000_003C, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFE_F000, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; address = '0; imm_out = '0;
    exp_tq = '0; exp_fq = '0; exp_vq = 1'b0;

    // Combinational vectors, applied while held in reset: reset must not matter.
    for (int i = 0; i < 8; i++) begin
      address = vecs[i].a; imm_out = vecs[i].b;
      #1;
      check_comb($sformatf("vec%0d", i), vecs[i].t, vecs[i].c, vecs[i].v, vecs[i].m);
    end

    // Registered path: two reset edges, one valid sample, then idle hold.
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, "rst0");
    step(1'b1, 1'b1, 32'd5, 32'd7, 1'b0, "rst1_prio");
    step(1'b0, 1'b1, 32'd12345678, 32'd1000, 1'b0, "cap");
    check("cap.value", 64'(target_q), 64'd12346678);
    step(1'b0, 1'b0, 32'd1, 32'd2, 1'b0, "idle");
    check("idle.held", 64'(target_q), 64'd12346678);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, "idle_x");

    // Back-to-back, then reset mid-stream discards the in-flight sample.
    step(1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, "b2b0");
    step(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "b2b1");
    step(1'b1, 1'b1, 32'd100, 32'hFFFF_FFD8, 1'b0, "midrst");
    step(1'b0, 1'b0, 32'd3, 32'd4, 1'b0, "postrst_idle");
    step(1'b0, 1'b1, 32'd100, 32'hFFFF_FFD8, 1'b0, "postrst_cap");

    // Randomized traffic with corner-value bias and X on idle cycles.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h7FFF_FFFF;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      if ($urandom_range(0, 19) == 0)
        step(1'b1, $urandom_range(0, 1) == 1, ra, rb, 1'b0, "rnd_rst");
      else if ($urandom_range(0, 3) == 0)
        step(1'b0, 1'b0, ra, rb, $urandom_range(0, 1) == 1, "rnd_idle");
      else
        step(1'b0, 1'b1, ra, rb, 1'b0, "rnd_val");
    end

    // Pure combinational random sweep.
    for (int i = 0; i < 100; i++) begin
      ra = $urandom; rb = $urandom;
      address = ra; imm_out = rb; in_valid = 1'b0;
      #1;
      model(ra, rb, t, c, v, m);
      check_comb("rnd_comb", t, c, v, m);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
